// File: rtl/mem_access_unit.sv
// Load/store unit between a core request port and a single-port word memory.
// Sub-word stores are done as read-modify-write so the memory only ever sees full words.
module mem_access_unit #(
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int unsigned DEPTH_WORDS = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready=1
    // LOAD  | memory read in flight, result captured on exit
    // MRD   | read half of a byte/halfword store
    // WRITE | mem_write high for exactly this period
    // RESP  | response held until resp_ready
    typedef enum logic [2:0] {IDLE, LOAD, MRD, WRITE, RESP} state_t;

    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

    state_t      state;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_lo;
    logic [31:0] offset;
    logic        req_err;

    always_comb begin
        offset  = req_addr - BASE_ADDR;
        req_err = 1'b0;
        case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = (req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
        if (offset >= SPAN) req_err = 1'b1;
    end

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                                 input logic sgn, input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   return {{24{sgn & b[7]}}, b};
            2'b01:   return {{16{sgn & h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [15:0] d,
                                                input logic [1:0] sz, input logic [1:0] a);
        logic [31:0] m;
        m = w;
        if (sz == 2'b00) m[{a, 3'b000} +: 8] = d[7:0];
        else if (a[1])   m[31:16] = d;
        else             m[15:0]  = d;
        return m;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            lane_q     <= '0;
            wdata_lo   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        lane_q    <= req_addr[1:0];
                        wdata_lo  <= req_wdata[15:0];
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        req_ready <= 1'b0;
                        if (req_err) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else if (!req_we) begin
                            state <= LOAD;
                        end else if (req_size == 2'b10) begin
                            mem_wdata <= req_wdata;
                            mem_write <= 1'b1;
                            state     <= WRITE;
                        end else begin
                            state <= MRD;
                        end
                    end
                end
                LOAD: begin
                    resp_rdata <= load_extract(mem_rdata, size_q, signed_q, lane_q);
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                MRD: begin
                    mem_wdata <= store_merge(mem_rdata, wdata_lo, size_q, lane_q);
                    mem_write <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: begin
                    mem_write  <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
